// File: rtl/key_debounce_multi_if.sv
// Key pins in, conditioned per-channel level and single-cycle event pulses out.
interface key_debounce_multi_if #(
  parameter int unsigned N = 4
);
  logic [N-1:0] key;
  logic [N-1:0] key_state;
  logic [N-1:0] press_pulse;
  logic [N-1:0] release_pulse;
  logic [N-1:0] long_pulse;
  logic [N-1:0] repeat_pulse;

  modport master (
    output key,
    input  key_state,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse,
    input  repeat_pulse
  );

  modport slave (
    input  key,
    output key_state,
    output press_pulse,
    output release_pulse,
    output long_pulse,
    output repeat_pulse
  );
endinterface

// File: rtl/key_debounce_multi.sv
// N-channel push-button conditioner: 2-FF synchroniser, stable-time filter and a per-channel
// press/hold/long FSM producing a clean level and single-cycle event pulses.
module key_debounce_multi #(
  parameter int unsigned N          = 4,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int unsigned STABLE_CYC = 3,
  parameter int unsigned LONG_CYC   = 100,
  parameter bit          REPEAT_EN  = 1'b0,
  parameter int unsigned REPEAT_CYC = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  key_debounce_multi_if.slave   keys_io
);

  localparam int unsigned StabW = $clog2(STABLE_CYC) + 1;
  localparam int unsigned HoldW = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;
  localparam int unsigned RepW  = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;

  localparam logic [StabW-1:0] StabMax = StabW'(STABLE_CYC - 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(LONG_CYC - 1);
  localparam logic [RepW-1:0]  RepMax  = RepW'(REPEAT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StHeld, StLong} state_e;

  logic [N-1:0] s1_q, s2_q;
  logic [N-1:0] key_sync;

  logic [N-1:0] ks_w, press_w, release_w, long_w, repeat_w;

  // Synchronisers idle at the released pin level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= {N{ACTIVE_LOW}};
      s2_q <= {N{ACTIVE_LOW}};
    end else begin
      s1_q <= keys_io.key;
      s2_q <= s1_q;
    end
  end

  assign key_sync = ACTIVE_LOW ? ~s2_q : s2_q;

  for (genvar c = 0; c < N; c++) begin : g_ch
    logic [StabW-1:0] stab_cnt_q;
    logic             ks_q;
    logic             diff;
    logic             accept;

    state_e           state_q;
    logic [HoldW-1:0] hold_cnt_q;
    logic [RepW-1:0]  rep_cnt_q;
    logic             press_q, release_q, long_q, repeat_q;

    assign diff   = key_sync[c] ^ ks_q;
    assign accept = diff && (stab_cnt_q == StabMax);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stab_cnt_q <= '0;
        ks_q       <= 1'b0;
      end else if (!diff) begin
        stab_cnt_q <= '0;
      end else if (accept) begin
        stab_cnt_q <= '0;
        ks_q       <= ~ks_q;
      end else begin
        stab_cnt_q <= stab_cnt_q + 1'b1;
      end
    end

    // Release is tested first in every held state so it beats a coincident long/repeat.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q    <= StIdle;
        hold_cnt_q <= '0;
        rep_cnt_q  <= '0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        long_q     <= 1'b0;
        repeat_q   <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
        unique case (state_q)
          StIdle: begin
            if (accept && !ks_q) begin
              press_q    <= 1'b1;
              hold_cnt_q <= '0;
              state_q    <= StHeld;
            end
          end
          StHeld: begin
            if (accept && ks_q) begin
              release_q <= 1'b1;
              state_q   <= StIdle;
            end else if (hold_cnt_q == HoldMax) begin
              long_q    <= 1'b1;
              rep_cnt_q <= '0;
              state_q   <= StLong;
            end else begin
              hold_cnt_q <= hold_cnt_q + 1'b1;
            end
          end
          StLong: begin
            if (accept && ks_q) begin
              release_q <= 1'b1;
              state_q   <= StIdle;
            end else if (REPEAT_EN) begin
              if (rep_cnt_q == RepMax) begin
                repeat_q  <= 1'b1;
                rep_cnt_q <= '0;
              end else begin
                rep_cnt_q <= rep_cnt_q + 1'b1;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end

    assign ks_w[c]      = ks_q;
    assign press_w[c]   = press_q;
    assign release_w[c] = release_q;
    assign long_w[c]    = long_q;
    assign repeat_w[c]  = repeat_q;
  end

  assign keys_io.key_state     = ks_w;
  assign keys_io.press_pulse   = press_w;
  assign keys_io.release_pulse = release_w;
  assign keys_io.long_pulse    = long_w;
  assign keys_io.repeat_pulse  = REPEAT_EN ? repeat_w : '0;

endmodule

// File: doc/key_debounce_multi.md
Name: key_debounce_multi

Overview:
- Parametrised N-channel push-button conditioner.
- Each raw key input passes through a 2-FF synchroniser and a per-channel stable-time filter.
- Produces a clean level plus one-cycle press, release, long-press and optional auto-repeat pulses.
- Sits between board pins and the control FSMs, which consume only single-cycle pulses.

Parameters:
N, 4, number of independent key channels
ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed
STABLE_CYC, 3, consecutive cycles a synchronised level must differ from the debounced state before it is accepted (>=1)
LONG_CYC, 100, cycles after press acceptance at which long_pulse fires (>STABLE_CYC)
REPEAT_EN, 0, 1 = enable repeat_pulse generation after a long press
REPEAT_CYC, 20, cycles between repeat pulses (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
key  input  N  raw key pins, asynchronous to clk
key_state  output  N  debounced level, 1 = pressed regardless of ACTIVE_LOW
press_pulse  output  N  one-cycle high when key_state goes 0->1
release_pulse  output  N  one-cycle high when key_state goes 1->0
long_pulse  output  N  one-cycle high when a press has been held LONG_CYC cycles
repeat_pulse  output  N  one-cycle high every REPEAT_CYC cycles after long_pulse while held; tied 0 when REPEAT_EN=0

Behaviour:
- Reset: one clock; rst_n is asynchronous, active-low.
  - All outputs reset to 0.
  - Synchroniser FFs reset to the released pin level (1 if ACTIVE_LOW, else 0).
  - All counters reset to 0; every FSM resets to IDLE.
- Synchroniser: key -> s1 -> s2 (key_sync), converted to logical pressed polarity.
- Stable filter, per channel:
  - diff = key_sync XOR key_state.
  - If diff = 0, stab_cnt clears to 0.
  - If diff = 1 and stab_cnt = STABLE_CYC-1, key_state toggles and stab_cnt clears.
  - Otherwise stab_cnt increments.
  - stab_cnt width = clog2(STABLE_CYC)+1.
- Latency: the first edge that samples a new stable pin level into s1 is E0. key_state toggles at edge E0+STABLE_CYC+1.
- Glitch rejection: any level lasting fewer than STABLE_CYC cycles in key_sync never changes key_state.
- Per-channel FSM, all outputs registered:
  - IDLE: on accept-press, go to HELD. press_pulse=1 for that cycle; hold_cnt=0.
  - HELD: hold_cnt increments each cycle.
    - At hold_cnt = LONG_CYC-1, long_pulse=1, rep_cnt=0, go to LONG.
    - On accept-release, release_pulse=1, go to IDLE.
  - LONG: if REPEAT_EN, rep_cnt increments; at rep_cnt = REPEAT_CYC-1, repeat_pulse=1 and rep_cnt=0. On accept-release, release_pulse=1, go to IDLE.
- Pulse timing: long_pulse is high exactly LONG_CYC edges after the press_pulse edge.
- Release priority: a release accepted in the same cycle a long or repeat would fire wins. Only release_pulse fires and the FSM goes to IDLE.
- Counter widths: hold_cnt = clog2(LONG_CYC); rep_cnt = clog2(REPEAT_CYC). No counter wraps; each is cleared or frozen outside its state.
- Channels are fully independent. Simultaneous events on different channels all produce their pulses in the same cycle.
- Reset mid-press: outputs drop to 0 immediately, with no release_pulse. A key still held after rst_n deasserts is re-accepted as a fresh press after STABLE_CYC+2 cycles.
- At most one of press/release/long/repeat is high per channel per cycle.

Test Plan:
- N=4, ACTIVE_LOW=1, STABLE_CYC=3: drive key[0] 1->0 and hold. key_state[0] and press_pulse[0] rise at edge E0+4. press_pulse is high exactly 1 cycle; other channels stay 0.
- Bounce: key[1] toggles 0/1 with 2-cycle pulses for 20 cycles, then stays 1 (released). No press_pulse[1]; key_state[1] stays 0 throughout.
- Long press, LONG_CYC=100, REPEAT_EN=0: hold key[2] for 300 cycles. One press_pulse; long_pulse exactly 100 cycles later; no further pulses. release_pulse occurs 4 cycles after the pin is released.
- Auto-repeat, REPEAT_EN=1, REPEAT_CYC=20: hold key[3] for 200 cycles past long_pulse. repeat_pulse fires at +20, +40 ... +200 (10 pulses), then release_pulse after release.
- Release collides with long: release accepted on the cycle hold_cnt = LONG_CYC-1. Only release_pulse fires; long_pulse stays 0; FSM returns to IDLE.
- Reset mid-hold: assert rst_n=0 while key[0] is held in LONG. All outputs drop asynchronously with no release_pulse. After deassertion with the key still held, press_pulse[0] fires 5 cycles later (STABLE_CYC+2).
